// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

   // Width of the word-count header carried at the front of the stream.
   localparam int COUNT_W = 16;

   // Stream bytes that make up one instruction word.
   localparam int BYTES_PER_WORD = 4;

   // Loader states. The FSM register holds these raw encodings.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CNT_LO = 3'd1;
   localparam logic [2:0] ST_CNT_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_FINISH = 3'd4;

   // Named view of the same encodings, for debug and waveform viewers.
   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      CNT_LO = ST_CNT_LO,
      CNT_HI = ST_CNT_HI,
      DATA   = ST_DATA,
      FINISH = ST_FINISH
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface imem_loader_if;
   import imem_loader_pkg::*;

   logic [7:0]                  byte_in;
   logic                        byte_valid;
   logic                        byte_ready;
   logic                        we;
   logic [31:0]                 wa;
   logic [8*BYTES_PER_WORD-1:0] wd;

   // Host side: it supplies bytes and observes the RAM writes.
   modport master (output byte_in, byte_valid, input byte_ready, we, wa, wd);

   // Loader side.
   modport slave (input byte_in, byte_valid, output byte_ready, we, wa, wd);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Places stream bytes into a little-endian 32-bit word. The completed word
// already includes the byte accepted this cycle, so the caller can register
// it on the same edge as the 4th accept.
module imem_loader_word_assembler (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_complete
);
   import imem_loader_pkg::*;

   logic [1:0] idx_reg;
   logic [7:0] lane_reg [BYTES_PER_WORD];

   // Byte index: advances on every accepted data byte and wraps after byte 3.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         idx_reg <= '0;
      else if (clear)
         idx_reg <= '0;
      else if (accept)
         idx_reg <= idx_reg + 2'd1;
   end

   generate
      for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         // Capture the byte into its lane when the index points here.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               lane_reg[gi] <= '0;
            else if (clear)
               lane_reg[gi] <= '0;
            else if (accept && idx_reg == 2'(gi))
               lane_reg[gi] <= byte_in;
         end

         // The current lane is bypassed so the full word is visible on the
         // cycle the last byte arrives.
         assign word[8*gi +: 8] = (idx_reg == 2'(gi)) ? byte_in : lane_reg[gi];
      end
   endgenerate

   assign word_complete = accept && (idx_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a word-count header followed by
// little-endian instruction words and writes them to consecutive addresses
// of the instruction RAM, holding the CPU until the image is complete.
module imem_loader #(
   parameter int DEPTH = 64
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   imem_loader_if.slave   bus,
   output logic           cpu_hold,
   output logic           done,
   output logic           error
);
   import imem_loader_pkg::*;

   localparam int K_W = $clog2(DEPTH) + 1;

   logic [2:0]         state_reg;
   logic [COUNT_W-1:0] count_reg;
   logic [K_W-1:0]     k_reg;
   logic               we_reg;
   logic [31:0]        wa_reg;
   logic [31:0]        wd_reg;
   logic               error_reg;

   logic               byte_ready;
   logic               accept;
   logic               asm_clear;
   logic               data_accept;
   logic [COUNT_W-1:0] count_full;
   logic [COUNT_W-1:0] k_plus_one;
   logic [31:0]        asm_word;
   logic               word_complete;

   assign byte_ready  = (state_reg == ST_CNT_LO) || (state_reg == ST_CNT_HI) ||
                        (state_reg == ST_DATA);
   assign accept      = bus.byte_valid && byte_ready;
   assign asm_clear   = (state_reg == ST_IDLE) && start;
   assign data_accept = accept && (state_reg == ST_DATA);
   // Full count as it will be once the high byte now on the bus is taken.
   assign count_full  = {bus.byte_in, count_reg[7:0]};
   assign k_plus_one  = COUNT_W'(k_reg) + COUNT_W'(1);

   imem_loader_word_assembler u_word_assembler (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (asm_clear),
      .accept        (data_accept),
      .byte_in       (bus.byte_in),
      .word          (asm_word),
      .word_complete (word_complete)
   );

   // Loader FSM, header/word counters and the registered RAM write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         k_reg     <= '0;
         we_reg    <= 1'b0;
         wa_reg    <= '0;
         wd_reg    <= '0;
         error_reg <= 1'b0;
      end else begin
         we_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg <= ST_CNT_LO;
                  error_reg <= 1'b0;
                  k_reg     <= '0;
               end
            end
            ST_CNT_LO: begin
               if (accept) begin
                  count_reg[7:0] <= bus.byte_in;
                  state_reg      <= ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (accept) begin
                  count_reg <= count_full;
                  if (count_full > COUNT_W'(DEPTH)) begin
                     error_reg <= 1'b1;
                     state_reg <= ST_IDLE;
                  end else if (count_full == '0) begin
                     state_reg <= ST_FINISH;
                  end else begin
                     state_reg <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (word_complete) begin
                  we_reg <= 1'b1;
                  wa_reg <= 32'({k_reg, 2'b00});
                  wd_reg <= asm_word;
                  k_reg  <= k_reg + K_W'(1);
                  if (k_plus_one == count_reg)
                     state_reg <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.byte_ready = byte_ready;
   assign bus.we         = we_reg;
   assign bus.wa         = wa_reg;
   assign bus.wd         = wd_reg;
   assign cpu_hold       = (state_reg != ST_IDLE);
   assign done           = (state_reg == ST_FINISH);
   assign error          = error_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: each load pushes its expected RAM writes,
// a negedge monitor pops and compares them as the DUT issues them.
module tb_imem_loader;

   localparam int DEPTH = 64;

   typedef logic [31:0] word_q_t [$];
   typedef struct {
      logic [31:0] wa;
      logic [31:0] wd;
      bit          last;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n;
   logic start;
   logic cpu_hold;
   logic done;
   logic error;

   imem_loader_if bus ();

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   int  vectors        = 0;
   int  miscompares    = 0;
   wr_t exp_q [$];
   int  exp_empty_done = 0;
   int  hold_run       = 0;
   int  last_hold_len  = 0;
   bit  done_prev      = 1'b0;
   wr_t mon_wr;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endfunction

   // Monitor: pops expected writes, checks done alignment and hold timing.
   always @(negedge clk) begin
      if (bus.we) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_we: got wa=0x%08h wd=0x%08h, required no write",
                     bus.wa, bus.wd);
         end else begin
            mon_wr = exp_q.pop_front();
            $display("write wa=0x%08h wd=0x%08h done=%0b (expect wa=0x%08h wd=0x%08h)",
                     bus.wa, bus.wd, done, mon_wr.wa, mon_wr.wd);
            check("write_wa", bus.wa, mon_wr.wa);
            check("write_wd", bus.wd, mon_wr.wd);
            check("done_with_last_we", 32'(done), 32'(mon_wr.last));
         end
      end else if (done) begin
         vectors++;
         if (exp_empty_done == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: got done=1 without write, required 0");
         end else begin
            exp_empty_done--;
         end
      end
      if (done_prev)
         check("hold_after_done", 32'(cpu_hold), 32'd0);
      done_prev = done;
      if (cpu_hold) begin
         hold_run++;
      end else if (hold_run != 0) begin
         last_hold_len = hold_run;
         hold_run      = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte and return one step after the edge that consumed it.
   task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit pulse_start);
      int waited;
      waited = 0;
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
         bus.byte_valid = 1'b0;
         bus.byte_in    = 8'($urandom);
         tick();
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      start          = pulse_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      while (!bus.byte_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.byte_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL byte_timeout: got byte_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Junk byte offered in IDLE first; it must not be consumed.
   task automatic do_start();
      bus.byte_valid = 1'b1;
      bus.byte_in    = 8'($urandom);
      tick();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start          = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int waited;
      waited = 0;
      while (cpu_hold && waited < 3000) begin
         tick();
         waited++;
      end
      if (cpu_hold) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got cpu_hold=1 after 3000 cycles, required 0");
      end
      tick();
      tick();
   endtask

   task automatic run_load(input word_q_t words, input int gap_mode, input bit pulse_start);
      int n;
      n = words.size();
      for (int i = 0; i < n; i++)
         exp_q.push_back('{wa: 32'(4 * i), wd: words[i], last: (i == n - 1)});
      if (n == 0)
         exp_empty_done++;
      do_start();
      check("error_cleared_by_start", 32'(error), 32'd0);
      check("hold_after_start", 32'(cpu_hold), 32'd1);
      send_byte(8'(n), gap_mode, pulse_start);
      send_byte(8'(n >> 8), gap_mode, pulse_start);
      for (int i = 0; i < n; i++)
         for (int j = 0; j < 4; j++)
            send_byte(words[i][8*j +: 8], gap_mode, pulse_start);
      bus.byte_valid = 1'b0;
      wait_idle();
      check("writes_outstanding", 32'(exp_q.size()), 32'd0);
      check("empty_done_outstanding", 32'(exp_empty_done), 32'd0);
      check("error_after_load", 32'(error), 32'd0);
      if (gap_mode == 0 && !pulse_start)
         check("hold_cycles", 32'(last_hold_len), 32'(3 + 4 * n));
      $display("load n=%0d gap_mode=%0d start_pulses=%0b hold=%0d", n, gap_mode,
               pulse_start, last_hold_len);
      exp_q.delete();
      exp_empty_done = 0;
   endtask

   task automatic run_overflow(input int n);
      do_start();
      send_byte(8'(n), 0, 1'b0);
      send_byte(8'(n >> 8), 0, 1'b0);
      bus.byte_valid = 1'b0;
      check("error_set", 32'(error), 32'd1);
      check("hold_after_error", 32'(cpu_hold), 32'd0);
      check("ready_after_error", 32'(bus.byte_ready), 32'd0);
      repeat (5) tick();
      check("error_sticky", 32'(error), 32'd1);
      check("overflow_hold_cycles", 32'(last_hold_len), 32'd2);
      $display("overflow n=%0d error=%0b", n, error);
   endtask

   task automatic run_abort();
      do_start();
      send_byte(8'h02, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h4B, 0, 1'b0);
      send_byte(8'h20, 0, 1'b0);
      bus.byte_valid = 1'b0;
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_we", 32'(bus.we), 32'd0);
      check("abort_wa", bus.wa, 32'd0);
      check("abort_wd", bus.wd, 32'd0);
      check("abort_ready", 32'(bus.byte_ready), 32'd0);
      check("abort_hold", 32'(cpu_hold), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      $display("abort after 2 data bytes, outputs cleared");
   endtask

   initial begin
      word_q_t w2;
      word_q_t empty;
      word_q_t r;

      reset_n        = 1'b1;
      start          = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'h00;
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_we", 32'(bus.we), 32'd0);
      check("reset_wa", bus.wa, 32'd0);
      check("reset_wd", bus.wd, 32'd0);
      check("reset_ready", 32'(bus.byte_ready), 32'd0);
      check("reset_hold", 32'(cpu_hold), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_error", 32'(error), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      tick();

      w2 = '{32'hE3A0204B, 32'hE04F000F};
      run_load(w2, 0, 1'b0);
      run_load(empty, 0, 1'b0);
      run_overflow(DEPTH + 1);
      run_overflow($urandom_range(DEPTH + 2, 65535));
      run_load(w2, 1, 1'b0);
      run_abort();
      run_load(w2, 0, 1'b0);

      r.delete();
      for (int i = 0; i < 5; i++) r.push_back($urandom);
      run_load(r, 0, 1'b1);

      r.delete();
      for (int i = 0; i < DEPTH; i++) r.push_back($urandom);
      run_load(r, 0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         r.delete();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++) r.push_back($urandom);
         run_load(r, 2, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for instruction memory: the write side of the instruction-memory interface the CPU fetches from. It accepts a byte stream (valid/ready) carrying a 16-bit word count and then little-endian 32-bit instruction words. It writes those words to consecutive word-aligned addresses of the instruction RAM and holds the CPU stalled until the image is complete. It sits between the host byte source (UART receiver or testbench) and the instruction RAM write port.

## Interface
- DEPTH, 64, instruction memory size in 32-bit words; maximum accepted word count.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE.
- byte_in  in  8  stream data byte.
- byte_valid  in  1  byte_in is valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- we  out  1  instruction RAM write enable, one cycle per word.
- wa  out  32  byte address of the write, always word-aligned (wa[1:0]=0).
- wd  out  32  instruction word to write.
- cpu_hold  out  1  CPU stall/hold, high whenever not IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky: word count exceeded DEPTH; cleared by next accepted start.

## Operation
- Accept = byte_valid && byte_ready.
- States: IDLE, CNT_LO, CNT_HI, DATA, FINISH.
- IDLE: byte_ready=0. On start, go to CNT_LO and clear error, the word index and the byte index.
- CNT_LO: on accept, N[7:0] = byte_in, go to CNT_HI.
- CNT_HI: on accept, N[15:8] = byte_in.
  - N > DEPTH: set error, go to IDLE, no writes.
  - N == 0: go to FINISH.
  - Otherwise: go to DATA.
- DATA: byte index j (0..3) places byte_in at word bits [8j+7:8j].
  - On accept with j=3, register we=1, wa=4*k and the assembled word on wd, then increment k (word index).
  - If k+1 == N, go to FINISH; else stay in DATA with j=0.
- FINISH: byte_ready=0, done=1 for exactly one cycle, then IDLE.
- byte_ready=1 in CNT_LO, CNT_HI, DATA; 0 otherwise.
- start outside IDLE is ignored.
- Bytes offered in IDLE or FINISH are not consumed.
- Word index is $clog2(DEPTH)+1 bits wide; N is 16 bits. The comparison against DEPTH is unsigned.
- wa = {k, 2'b00}, zero-extended to 32 bits.

## Timing
- Reset (async, reset_n=0): state=IDLE; byte_ready, we, cpu_hold, done, error = 0; wa, wd = 0. A partial word is discarded and nothing is written.
- Write latency: we/wa/wd are valid the cycle after the 4th byte of a word is accepted.
- we is high for exactly one cycle per word; wa/wd hold their last value when we=0.
- The last word's we coincides with the FINISH cycle, i.e. with done.
- cpu_hold rises the cycle after start is accepted and falls the cycle after FINISH (or after the error transition).
- Throughput: one byte per cycle with byte_valid held high. An N-word load takes 2+4N accept cycles plus one FINISH cycle.
- Gaps in byte_valid stall progress without any effect on the assembled word.
- error rises the cycle after the CNT_HI accept; done is not pulsed on error.

## Structure
- Package imem_loader_pkg:
  - state enum (IDLE, CNT_LO, CNT_HI, DATA, FINISH);
  - localparam for count width (16);
  - localparam for bytes per word (4).
- One sub-module, word_assembler: a byte shift/placement register with a 2-bit byte index and a word-complete strobe. The top holds the FSM, counters and the write-port registers.

## Test plan
- Reset: drive reset_n=0 mid-cycle -> all outputs 0 immediately, state IDLE, byte_ready=0.
- Two-word load: start, bytes 02 00 4B 20 A0 E3 0F 00 4F E0 with valid held -> we@wa=0x0 wd=0xE3A0204B, then we@wa=0x4 wd=0xE04F000F; done high in the same cycle as the second we; cpu_hold low the next cycle.
- Empty image: start, bytes 00 00 -> FINISH, done one cycle, no we; cpu_hold high for exactly 3 cycles after start.
- Overflow: DEPTH=64, start, bytes 41 00 -> error=1, no we, no done, IDLE. A later start clears error.
- Backpressure and abort: same two-word image with byte_valid toggling every cycle -> identical writes. Then a new load with reset_n pulsed low after 2 data bytes -> no we, outputs 0; the next start loads correctly from wa=0.
- start pulsed repeatedly during DATA -> ignored; write sequence and count unchanged.
